mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Sits directly upstream of the PSRAM memory controller and is the only driver of its CE, write, bank, addrBus and dataToWrite inputs.
- Accepts 8-bit access requests from two masters:
  - CPU: read or write.
  - VIC video DMA: read only.
- Arbitrates between them and sequences exactly one controller transaction at a time, using the controller's busy line.
- Returns read data and a one-cycle acknowledge to the granted master.

Parameters:
- ACCEPT_TIMEOUT, 8: max cycles after the CE pulse that busy may take to rise before the transaction is reissued.
- VIC_BANK, 6'd0: bank value driven for VIC accesses.

Ports:
- clk  in  1  system RAM clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_bank  in  6  bank for CPU access.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  CPU read data; valid in the cpu_ack cycle and held until the next CPU read completes.
- vic_req  in  1  VIC read request; held until vic_ack.
- vic_addr  in  16  VIC address.
- vic_ack  out  1  one-cycle completion pulse.
- vic_rdata  out  8  VIC read data; valid in the vic_ack cycle and held until the next VIC read completes.
- mem_ce  out  1  to controller CE; one-cycle pulse.
- mem_write  out  1  to controller write.
- mem_bank  out  6  to controller bank.
- mem_addr  out  16  to controller addrBus.
- mem_wdata  out  8  to controller dataToWrite.
- mem_rdata  in  8  from controller dataRead.
- mem_busy  in  1  from controller busy.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, including cpu_rdata and vic_rdata.
  - Round-robin pointer = VIC.
  - Reset mid-transaction abandons it; no ack is issued.
- Controller handshake: a transaction starts with a single-cycle mem_ce; it is accepted when mem_busy rises and completes when mem_busy falls.
- IDLE:
  - Transition only if mem_busy = 0. This covers the controller's post-reset init, during which it holds busy high.
  - Grant by fixed priority, VIC over CPU.
  - On grant, latch master id, we, bank, addr and wdata into the mem_* output registers, then go to ISSUE.
  - VIC accesses use mem_write = 0, mem_bank = VIC_BANK, mem_wdata = 0.
- ISSUE: mem_ce = 1 for exactly this cycle; clear the timeout counter; go to WAIT_ACCEPT.
- WAIT_ACCEPT:
  - mem_busy = 1 → WAIT_DONE.
  - Counter reaches ACCEPT_TIMEOUT → ISSUE again with the same latched values (retry, unbounded).
- WAIT_DONE:
  - mem_busy = 0 → capture mem_rdata into the granted master's rdata register (reads only; writes leave rdata unchanged).
  - Pulse that master's ack on the next cycle (state RESP), then go to IDLE.
- Output stability: mem_write, mem_bank, mem_addr and mem_wdata are held constant from ISSUE through RESP.
- Latency:
  - Request sampled in IDLE at cycle N gives mem_ce at N+1.
  - Busy falling (sampled) at cycle M gives ack at M+1.
  - Minimum one IDLE cycle between back-to-back transactions.
- Withdrawn request:
  - Before grant: dropped silently.
  - After grant: the transaction completes and the ack is still pulsed; masters tolerate this.
- Simultaneous requests: only one is granted. The other stays pending, and is evaluated again in the next IDLE cycle.
- cpu_ack and vic_ack are never high in the same cycle.

Optional Feature:
- Macro MEMARB_ROUND_ROBIN_EN.
- Defined:
  - When both masters request in IDLE, grant the master not served last.
  - The pointer updates on each grant.
  - A lone requester is always granted.
- Undefined: fixed VIC-over-CPU priority; the pointer logic is absent.

Decomposition:
- Package memarb_pkg holds:
  - State enum: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESP.
  - Master-id constants: MST_CPU = 1'b0, MST_VIC = 1'b1.
  - Width constants: ADDR_W = 16, DATA_W = 8, BANK_W = 6.
- Sub-module memarb_pick: combinational grant selection (priority or round-robin) from the two requests and the pointer.

Test Plan:
- Post-reset busy: reset for 2 cycles, mem_busy held high for 100 cycles, cpu_req = 1 → no mem_ce until busy falls; mem_ce exactly 1 cycle after.
- CPU write: cpu_we = 1, addr 16'hC000, bank 6'h03, wdata 8'hA5, model asserts busy 2 cycles after CE for 10 cycles → mem_addr = C000, mem_bank = 03, mem_wdata = A5 stable throughout; cpu_ack one cycle after busy falls; cpu_rdata unchanged (0).
- VIC read: addr 16'h0400, model returns 8'h3C → vic_ack pulse, vic_rdata = 3C, mem_write = 0, mem_bank = VIC_BANK.
- Simultaneous requests:
  - Both requesting, fixed priority → VIC first, then CPU; acks never coincide.
  - With MEMARB_ROUND_ROBIN_EN, two consecutive double requests → order VIC, CPU, VIC, CPU.
- Accept timeout: model ignores the first CE → second mem_ce exactly ACCEPT_TIMEOUT+1 cycles later with identical addr/data; a single ack results.
- Reset mid-transaction: reset asserted in WAIT_DONE → next cycle state IDLE, all outputs 0, no ack.

Source files
------------

// File: rtl/memarb_pkg.sv
// memarb_pkg: shared types and constants for the PSRAM request arbiter.
// Build option MEMARB_ROUND_ROBIN_EN turns on round-robin arbitration.
package memarb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int BANK_W = 6;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_VIC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_DONE,
        RESP
    } arbStateT;

endpackage

// File: rtl/memarb_pick.sv
// memarb_pick: combinational grant selection between CPU and VIC.
// MEMARB_ROUND_ROBIN_EN: pointer decides ties, else VIC wins.
module memarb_pick
    import memarb_pkg::*;
(
    input  logic cpuReq,
    input  logic vicReq,
`ifdef MEMARB_ROUND_ROBIN_EN
    input  logic rrPtr,
`endif
    output logic grantValid,
    output logic grantId
);

    // Pick the winner; a lone requester always wins.
    always_comb begin
        grantValid = cpuReq | vicReq;
        grantId    = MST_CPU;
`ifdef MEMARB_ROUND_ROBIN_EN
        if (cpuReq && vicReq) begin
            grantId = rrPtr;
        end else if (vicReq) begin
            grantId = MST_VIC;
        end
`else
        if (vicReq) begin
            grantId = MST_VIC;
        end
`endif
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: sequences CPU / VIC accesses onto the PSRAM controller.
// Define MEMARB_ROUND_ROBIN_EN for round-robin instead of VIC priority.
module mem_req_arbiter
    import memarb_pkg::*;
#(
    parameter int                ACCEPT_TIMEOUT = 8,
    parameter logic [BANK_W-1:0] VIC_BANK       = 6'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [BANK_W-1:0] cpu_bank,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vic_req,
    input  logic [ADDR_W-1:0] vic_addr,
    output logic              vic_ack,
    output logic [DATA_W-1:0] vic_rdata,
    output logic              mem_ce,
    output logic              mem_write,
    output logic [BANK_W-1:0] mem_bank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy
);

    localparam int               CNT_W    = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);

    arbStateT         state;
    logic             curMst;
    logic [CNT_W-1:0] acceptCnt;
    logic             grantValid;
    logic             grantId;

`ifdef MEMARB_ROUND_ROBIN_EN
    // Master favoured on the next tie; flips to the other one on every grant.
    logic             rrPtr;
`endif

    memarb_pick uPick (
        .cpuReq     (cpu_req),
        .vicReq     (vic_req),
`ifdef MEMARB_ROUND_ROBIN_EN
        .rrPtr      (rrPtr),
`endif
        .grantValid (grantValid),
        .grantId    (grantId)
    );

    // Transaction sequencer with registered controller and master outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            curMst    <= MST_CPU;
            acceptCnt <= '0;
            mem_ce    <= 1'b0;
            mem_write <= 1'b0;
            mem_bank  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            vic_ack   <= 1'b0;
            cpu_rdata <= '0;
            vic_rdata <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
            rrPtr     <= MST_VIC;
`endif
        end else begin
            mem_ce  <= 1'b0;
            cpu_ack <= 1'b0;
            vic_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Busy high here also covers the controller's init phase.
                    if (!mem_busy && grantValid) begin
                        curMst <= grantId;
                        mem_ce <= 1'b1;
                        state  <= ISSUE;
`ifdef MEMARB_ROUND_ROBIN_EN
                        rrPtr  <= ~grantId;
`endif
                        if (grantId == MST_VIC) begin
                            mem_write <= 1'b0;
                            mem_bank  <= VIC_BANK;
                            mem_addr  <= vic_addr;
                            mem_wdata <= '0;
                        end else begin
                            mem_write <= cpu_we;
                            mem_bank  <= cpu_bank;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ISSUE: begin
                    acceptCnt <= '0;
                    state     <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    if (mem_busy) begin
                        state <= WAIT_DONE;
                    end else if (acceptCnt == CNT_LAST) begin
                        // Controller missed the CE: pulse again, same payload.
                        mem_ce <= 1'b1;
                        state  <= ISSUE;
                    end else begin
                        acceptCnt <= acceptCnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!mem_busy) begin
                        state <= RESP;
                        if (curMst == MST_VIC) begin
                            vic_ack   <= 1'b1;
                            vic_rdata <= mem_rdata;
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!mem_write) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized + directed bench with a behavioural
// PSRAM controller model and a transaction-level reference.
module tb_mem_req_arbiter;
    import memarb_pkg::*;

    localparam int         ACC_TO = 8;
    localparam logic [5:0] VBANK  = 6'h2A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [5:0]  cpu_bank = '0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vic_req = 1'b0;
    logic [15:0] vic_addr = '0;
    logic        vic_ack;
    logic [7:0]  vic_rdata;
    logic        mem_ce, mem_write;
    logic [5:0]  mem_bank;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_busy;
    bit          holdBusy = 1'b0, txBusy = 1'b0;

    assign mem_busy = holdBusy | txBusy;

    mem_req_arbiter #(.ACCEPT_TIMEOUT(ACC_TO), .VIC_BANK(VBANK)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vic_req(vic_req), .vic_addr(vic_addr),
        .vic_ack(vic_ack), .vic_rdata(vic_rdata),
        .mem_ce(mem_ce), .mem_write(mem_write), .mem_bank(mem_bank),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit we; logic [5:0] bank; logic [15:0] addr; logic [7:0] wdata; int cyc;
    } ceRecT;
    typedef struct {
        bit we; logic [5:0] bank; logic [15:0] addr; logic [7:0] wdata; int fallCyc;
    } txnRecT;
    typedef struct {
        bit mst; logic [7:0] rdata; int cyc;
    } ackRecT;

    ceRecT  ceLog[$];
    txnRecT txnLog[$];
    ackRecT ackLog[$];

    logic [7:0] ctlMem[bit [21:0]];
    logic [7:0] refMem[bit [21:0]];

    // Reference-side state
    bit         rrNext = MST_VIC;
    logic [7:0] expCpuRd = '0;
    logic [7:0] expVicRd = '0;

    function automatic logic [7:0] defByte(input bit [21:0] k);
        return k[7:0] ^ k[15:8] ^ {2'b00, k[21:16]};
    endfunction

    function automatic logic [7:0] refRead(input bit [21:0] k);
        if (refMem.exists(k)) return refMem[k];
        return defByte(k);
    endfunction

    // Controller model knobs / status
    int acceptDelay = 2, busyLen = 10, ignoreCnt = 0, stabErr = 0;
    int ph = 0, mcnt = 0;
    txnRecT cur;

    // PSRAM controller model: CE -> busy after acceptDelay, for busyLen cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                ph = 0;
                txBusy = 1'b0;
            end else begin
                if (ph != 0) begin
                    if (mem_write !== cur.we || mem_bank !== cur.bank ||
                        mem_addr !== cur.addr || mem_wdata !== cur.wdata)
                        stabErr++;
                end
                case (ph)
                    0: if (mem_ce === 1'b1) begin
                        ceLog.push_back('{mem_write, mem_bank, mem_addr, mem_wdata, cyc});
                        if (ignoreCnt > 0) begin
                            ignoreCnt--;
                        end else begin
                            cur.we = mem_write; cur.bank = mem_bank;
                            cur.addr = mem_addr; cur.wdata = mem_wdata;
                            ph = 1; mcnt = acceptDelay - 1;
                        end
                    end
                    1: if (mcnt == 0) begin
                        txBusy = 1'b1; mcnt = busyLen - 1; ph = 2;
                    end else mcnt--;
                    2: if (mcnt == 0) begin
                        txBusy = 1'b0;
                        if (cur.we) ctlMem[{cur.bank, cur.addr}] = cur.wdata;
                        else if (ctlMem.exists({cur.bank, cur.addr}))
                            mem_rdata = ctlMem[{cur.bank, cur.addr}];
                        else mem_rdata = defByte({cur.bank, cur.addr});
                        cur.fallCyc = cyc;
                        txnLog.push_back(cur);
                        ph = 3;
                    end else mcnt--;
                    default: ph = 0;
                endcase
            end
        end
    end

    int bothAck = 0;

    // Ack monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_ack === 1'b1 && vic_ack === 1'b1) bothAck++;
            if (cpu_ack === 1'b1) ackLog.push_back('{MST_CPU, cpu_rdata, cyc});
            if (vic_ack === 1'b1) ackLog.push_back('{MST_VIC, vic_rdata, cyc});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic clear_logs();
        ceLog.delete(); txnLog.delete(); ackLog.delete();
        stabErr = 0; bothAck = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0; vic_req = 1'b0; holdBusy = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0;
        rrNext = MST_VIC; expCpuRd = '0; expVicRd = '0;
        clear_logs();
    endtask

    task automatic run_reqs(input bit doCpu, input bit doVic, input int budget,
                            output bit timedOut);
        int n;
        @(posedge clk); #1;
        cpu_req = doCpu; vic_req = doVic;
        n = 0;
        while ((cpu_req || vic_req) && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (cpu_ack) cpu_req = 1'b0;
            if (vic_ack) vic_req = 1'b0;
        end
        timedOut = cpu_req | vic_req;
        cpu_req = 1'b0; vic_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if ({mem_ce, mem_write, mem_bank, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got %b %b %h %h %h expected all 0",
                     mem_ce, mem_write, mem_bank, mem_addr, mem_wdata);
        end
        checks++;
        if ({cpu_ack, vic_ack, cpu_rdata, vic_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_master: got %b %b %h %h expected all 0",
                     cpu_ack, vic_ack, cpu_rdata, vic_rdata);
        end
    endtask

    task automatic test_cpu_write();
        bit to;
        clear_logs();
        acceptDelay = 2; busyLen = 10; ignoreCnt = 0;
        cpu_we = 1'b1; cpu_addr = 16'hC000; cpu_bank = 6'h03; cpu_wdata = 8'hA5;
        refMem[{6'h03, 16'hC000}] = 8'hA5;
        run_reqs(1'b1, 1'b0, 200, to);
        checks++;
        if (to) begin errors++; $display("FAIL wr_timeout: no cpu_ack within budget"); end
        checks++;
        if (txnLog.size() != 1 || ackLog.size() != 1) begin
            errors++;
            $display("FAIL wr_count: got txn=%0d ack=%0d expected 1 1",
                     txnLog.size(), ackLog.size());
        end else begin
            checks++;
            if ({txnLog[0].we, txnLog[0].bank, txnLog[0].addr, txnLog[0].wdata} !==
                {1'b1, 6'h03, 16'hC000, 8'hA5}) begin
                errors++;
                $display("FAIL wr_payload: got we=%b bank=%h addr=%h data=%h expected 1 03 C000 A5",
                         txnLog[0].we, txnLog[0].bank, txnLog[0].addr, txnLog[0].wdata);
            end
            checks++;
            if (ackLog[0].mst !== MST_CPU || ackLog[0].cyc != txnLog[0].fallCyc + 1) begin
                errors++;
                $display("FAIL wr_ack: got mst=%b cyc=%0d expected CPU at %0d",
                         ackLog[0].mst, ackLog[0].cyc, txnLog[0].fallCyc + 1);
            end
        end
        checks++;
        if (stabErr != 0) begin
            errors++; $display("FAIL wr_stable: got %0d changes expected 0", stabErr);
        end
        checks++;
        if (cpu_rdata !== 8'h00) begin
            errors++; $display("FAIL wr_rdata: got %h expected 00", cpu_rdata);
        end
    endtask

    task automatic test_vic_read();
        bit to;
        clear_logs();
        acceptDelay = 2; busyLen = 4;
        ctlMem[{VBANK, 16'h0400}] = 8'h3C;
        refMem[{VBANK, 16'h0400}] = 8'h3C;
        vic_addr = 16'h0400;
        run_reqs(1'b0, 1'b1, 200, to);
        checks++;
        if (to) begin errors++; $display("FAIL vic_timeout: no vic_ack within budget"); end
        checks++;
        if (vic_rdata !== 8'h3C) begin
            errors++; $display("FAIL vic_rdata: got %h expected 3C", vic_rdata);
        end
        checks++;
        if (txnLog.size() != 1 || ackLog.size() != 1) begin
            errors++;
            $display("FAIL vic_count: got txn=%0d ack=%0d expected 1 1",
                     txnLog.size(), ackLog.size());
        end else begin
            checks++;
            if ({txnLog[0].we, txnLog[0].bank, txnLog[0].addr, txnLog[0].wdata} !==
                {1'b0, VBANK, 16'h0400, 8'h00}) begin
                errors++;
                $display("FAIL vic_payload: got we=%b bank=%h addr=%h data=%h expected 0 %h 0400 00",
                         txnLog[0].we, txnLog[0].bank, txnLog[0].addr, txnLog[0].wdata, VBANK);
            end
            checks++;
            if (ackLog[0].mst !== MST_VIC || ackLog[0].rdata !== 8'h3C) begin
                errors++;
                $display("FAIL vic_ack: got mst=%b data=%h expected VIC 3C",
                         ackLog[0].mst, ackLog[0].rdata);
            end
        end
        expVicRd = 8'h3C;
    endtask

    task automatic test_post_reset_busy();
        int drop, n;
        logic [7:0] exp;
        @(posedge clk); #1;
        reset = 1'b1; holdBusy = 1'b1;
        cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_bank = 6'h05; cpu_req = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        rrNext = MST_VIC; expCpuRd = '0; expVicRd = '0;
        clear_logs();
        acceptDelay = 2; busyLen = 3;
        repeat (100) begin @(posedge clk); #1; end
        checks++;
        if (ceLog.size() != 0) begin
            errors++; $display("FAIL init_ce: got %0d CE while busy expected 0", ceLog.size());
        end
        drop = cyc;
        holdBusy = 1'b0;
        n = 0;
        while (cpu_req && n < 200) begin
            @(posedge clk); #1; n++;
            if (cpu_ack) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        checks++;
        if (n >= 200) begin errors++; $display("FAIL init_timeout: no cpu_ack within budget"); end
        checks++;
        if (ceLog.size() < 1 || ceLog[0].cyc != drop + 1) begin
            errors++;
            $display("FAIL init_ce_time: got n=%0d cyc=%0d expected cyc %0d", ceLog.size(),
                     (ceLog.size() > 0) ? ceLog[0].cyc : -1, drop + 1);
        end
        exp = refRead({6'h05, 16'h0010});
        expCpuRd = exp;
        checks++;
        if (cpu_rdata !== exp) begin
            errors++; $display("FAIL init_rdata: got %h expected %h", cpu_rdata, exp);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        bit to;
        logic [7:0] ev, ec;
        do_reset(2);
        acceptDelay = 1; busyLen = 2;
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            cpu_we = 1'b0; cpu_bank = 6'h01; cpu_addr = 16'h0100 + 16'(r);
            vic_addr = 16'h0200 + 16'(r);
            ev = refRead({VBANK, vic_addr});
            ec = refRead({6'h01, cpu_addr});
            run_reqs(1'b1, 1'b1, 300, to);
            checks++;
            if (to) begin errors++; $display("FAIL sim_timeout: round %0d", r); end
            checks++;
            if (ackLog.size() != 2) begin
                errors++; $display("FAIL sim_count: got %0d acks expected 2", ackLog.size());
            end else begin
                checks++;
                if (ackLog[0].mst !== MST_VIC || ackLog[1].mst !== MST_CPU) begin
                    errors++;
                    $display("FAIL sim_order: got %b,%b expected VIC,CPU",
                             ackLog[0].mst, ackLog[1].mst);
                end
                checks++;
                if (ackLog[0].rdata !== ev || ackLog[1].rdata !== ec) begin
                    errors++;
                    $display("FAIL sim_data: got %h,%h expected %h,%h",
                             ackLog[0].rdata, ackLog[1].rdata, ev, ec);
                end
            end
            checks++;
            if (bothAck != 0) begin
                errors++; $display("FAIL sim_coincide: got %0d overlapping acks expected 0", bothAck);
            end
            expVicRd = ev; expCpuRd = ec;
        end
        rrNext = MST_VIC;
    endtask

    task automatic test_timeout();
        bit to;
        clear_logs();
        acceptDelay = 2; busyLen = 3; ignoreCnt = 1;
        cpu_we = 1'b1; cpu_bank = 6'h07; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
        refMem[{6'h07, 16'h1234}] = 8'h5A;
        run_reqs(1'b1, 1'b0, 300, to);
        checks++;
        if (to) begin errors++; $display("FAIL to_timeout: no cpu_ack within budget"); end
        checks++;
        if (ceLog.size() != 2) begin
            errors++; $display("FAIL to_ce_count: got %0d expected 2", ceLog.size());
        end else begin
            checks++;
            if (ceLog[1].cyc - ceLog[0].cyc != ACC_TO + 1) begin
                errors++;
                $display("FAIL to_gap: got %0d expected %0d",
                         ceLog[1].cyc - ceLog[0].cyc, ACC_TO + 1);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({ceLog[i].we, ceLog[i].bank, ceLog[i].addr, ceLog[i].wdata} !==
                    {1'b1, 6'h07, 16'h1234, 8'h5A}) begin
                    errors++;
                    $display("FAIL to_payload%0d: got %b %h %h %h expected 1 07 1234 5A", i,
                             ceLog[i].we, ceLog[i].bank, ceLog[i].addr, ceLog[i].wdata);
                end
            end
        end
        checks++;
        if (ackLog.size() != 1) begin
            errors++; $display("FAIL to_acks: got %0d expected 1", ackLog.size());
        end
        ignoreCnt = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        acceptDelay = 2; busyLen = 20;
        cpu_we = 1'b0; cpu_bank = 6'h01; cpu_addr = 16'h0777;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        n = 0;
        while (!txBusy && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL mid_busy: controller never went busy"); end
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_ce, mem_write, mem_bank, mem_addr, mem_wdata,
             cpu_ack, vic_ack, cpu_rdata, vic_rdata} !== '0) begin
            errors++;
            $display("FAIL mid_outputs: got ce=%b addr=%h bank=%h ack=%b%b rd=%h/%h expected all 0",
                     mem_ce, mem_addr, mem_bank, cpu_ack, vic_ack, cpu_rdata, vic_rdata);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rrNext = MST_VIC; expCpuRd = '0; expVicRd = '0;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (ackLog.size() != 0) begin
            errors++; $display("FAIL mid_ack: got %0d acks expected 0", ackLog.size());
        end
    endtask

    task automatic test_random();
        bit to, doCpu, doVic, first, mst;
        int sel, n;
        bit expMst[2], expWe[2];
        logic [5:0] expBank[2];
        logic [15:0] expAddr[2];
        logic [7:0] expWd[2], expRd[2];
        do_reset(2);
        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(1, 3);
            doCpu = sel[0]; doVic = sel[1];
            acceptDelay = $urandom_range(1, 4);
            busyLen = $urandom_range(1, 6);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_bank = ($urandom_range(0, 1) == 1) ? VBANK : 6'($urandom_range(0, 63));
            cpu_addr = 16'h3000 + 16'($urandom_range(0, 7));
            cpu_wdata = 8'($urandom);
            vic_addr = 16'h3000 + 16'($urandom_range(0, 7));
            if (doCpu && doVic) begin
`ifdef MEMARB_ROUND_ROBIN_EN
                first = rrNext;
`else
                first = MST_VIC;
`endif
                n = 2; expMst[0] = first; expMst[1] = ~first;
            end else begin
                n = 1; expMst[0] = doVic ? MST_VIC : MST_CPU; expMst[1] = MST_CPU;
            end
            for (int k = 0; k < n; k++) begin
                mst = expMst[k];
                rrNext = ~mst;
                if (mst == MST_VIC) begin
                    expWe[k] = 1'b0; expBank[k] = VBANK; expAddr[k] = vic_addr;
                    expWd[k] = 8'h00; expRd[k] = refRead({VBANK, vic_addr});
                    expVicRd = expRd[k];
                end else begin
                    expWe[k] = cpu_we; expBank[k] = cpu_bank; expAddr[k] = cpu_addr;
                    expWd[k] = cpu_we ? cpu_wdata : 8'h00;
                    if (cpu_we) begin
                        refMem[{cpu_bank, cpu_addr}] = cpu_wdata;
                        expRd[k] = expCpuRd;
                    end else begin
                        expRd[k] = refRead({cpu_bank, cpu_addr});
                        expCpuRd = expRd[k];
                    end
                end
            end
            clear_logs();
            run_reqs(doCpu, doVic, 300, to);
            checks++;
            if (to) begin errors++; $display("FAIL rnd_timeout: round %0d", r); end
            checks++;
            if (ackLog.size() != n || txnLog.size() != n) begin
                errors++;
                $display("FAIL rnd_count: round %0d got ack=%0d txn=%0d expected %0d",
                         r, ackLog.size(), txnLog.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (ackLog[k].mst !== expMst[k] || ackLog[k].rdata !== expRd[k] ||
                        ackLog[k].cyc != txnLog[k].fallCyc + 1) begin
                        errors++;
                        $display("FAIL rnd_ack: round %0d #%0d got mst=%b rd=%h cyc=%0d expected %b %h %0d",
                                 r, k, ackLog[k].mst, ackLog[k].rdata, ackLog[k].cyc,
                                 expMst[k], expRd[k], txnLog[k].fallCyc + 1);
                    end
                    checks++;
                    if ({txnLog[k].we, txnLog[k].bank, txnLog[k].addr} !==
                        {expWe[k], expBank[k], expAddr[k]} ||
                        (expWe[k] || expMst[k] == MST_VIC) && txnLog[k].wdata !== expWd[k]) begin
                        errors++;
                        $display("FAIL rnd_txn: round %0d #%0d got %b %h %h %h expected %b %h %h %h",
                                 r, k, txnLog[k].we, txnLog[k].bank, txnLog[k].addr,
                                 txnLog[k].wdata, expWe[k], expBank[k], expAddr[k], expWd[k]);
                    end
                end
            end
            checks++;
            if (stabErr != 0 || bothAck != 0) begin
                errors++;
                $display("FAIL rnd_stable: round %0d got stab=%0d both=%0d expected 0 0",
                         r, stabErr, bothAck);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_vic_read();
        test_post_reset_busy();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
